// File: rtl/mem_arbiter.sv
// Arbitrates the byte-serial memory controller between instruction fetch, load
// buffer and committed stores: fixed priority ST > LB > IF, with an IF starvation guard.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_ack_out,
  output logic [31:0] if_data_out,
  input  logic        lb_req_in,
  input  logic [31:0] lb_addr_in,
  input  logic [1:0]  lb_len_in,
  output logic        lb_ack_out,
  output logic [31:0] lb_data_out,
  input  logic        st_req_in,
  input  logic [31:0] st_addr_in,
  input  logic [1:0]  st_len_in,
  input  logic [31:0] st_data_in,
  output logic        st_ack_out,
  output logic        mc_start_out,
  output logic        mc_rw_out,
  output logic [31:0] mc_addr_out,
  output logic [1:0]  mc_len_out,
  output logic [31:0] mc_data_out,
  input  logic        mc_done_in,
  input  logic [31:0] mc_data_in
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LB, OWN_ST} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d, win;
  logic              discard_q, discard_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              if_pend_q, if_pend_d, lb_pend_q, lb_pend_d, st_pend_q, st_pend_d;
  logic [31:0]       if_addr_q, if_addr_d, lb_addr_q, lb_addr_d, st_addr_q, st_addr_d;
  logic [1:0]        lb_len_q, lb_len_d, st_len_q, st_len_d;
  logic [31:0]       st_data_q, st_data_d;
  logic              mc_start_q, mc_start_d, mc_rw_q, mc_rw_d;
  logic [31:0]       mc_addr_q, mc_addr_d, mc_data_q, mc_data_d;
  logic [1:0]        mc_len_q, mc_len_d;
  logic              if_ack_q, if_ack_d, lb_ack_q, lb_ack_d, st_ack_q, st_ack_d;
  logic [31:0]       if_data_q, if_data_d, lb_data_q, lb_data_d;
  logic              if_cand, lb_cand, st_cand, grant, done, suppress;

  // A flush removes speculative requesters from this edge's decision.
  assign if_cand = if_pend_q & ~flush_in;
  assign lb_cand = lb_pend_q & ~flush_in;
  assign st_cand = st_pend_q;
  assign grant   = (state_q == IDLE) & (if_cand | lb_cand | st_cand);
  assign done    = (state_q == WAIT) & mc_done_in;

  always_comb begin
    win = OWN_IF;
    if (if_cand && starve_q == LIMIT) win = OWN_IF;
    else if (st_cand)                 win = OWN_ST;
    else if (lb_cand)                 win = OWN_LB;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    discard_d  = discard_q;
    starve_d   = starve_q;
    if_pend_d  = if_pend_q;
    lb_pend_d  = lb_pend_q;
    st_pend_d  = st_pend_q;
    if_addr_d  = if_addr_q;
    lb_addr_d  = lb_addr_q;
    st_addr_d  = st_addr_q;
    lb_len_d   = lb_len_q;
    st_len_d   = st_len_q;
    st_data_d  = st_data_q;
    mc_start_d = 1'b0;
    mc_rw_d    = mc_rw_q;
    mc_addr_d  = mc_addr_q;
    mc_len_d   = mc_len_q;
    mc_data_d  = mc_data_q;
    if_ack_d   = 1'b0;
    lb_ack_d   = 1'b0;
    st_ack_d   = 1'b0;
    if_data_d  = if_data_q;
    lb_data_d  = lb_data_q;
    suppress   = discard_q | (flush_in & (owner_q != OWN_ST));

    if (grant) begin
      state_d    = WAIT;
      owner_d    = win;
      mc_start_d = 1'b1;
      unique case (win)
        OWN_ST: begin
          mc_rw_d = 1'b1; mc_addr_d = st_addr_q; mc_len_d = st_len_q; mc_data_d = st_data_q;
        end
        OWN_LB: begin
          mc_rw_d = 1'b0; mc_addr_d = lb_addr_q; mc_len_d = lb_len_q; mc_data_d = '0;
        end
        default: begin
          mc_rw_d = 1'b0; mc_addr_d = if_addr_q; mc_len_d = 2'd3; mc_data_d = '0;
        end
      endcase
    end

    if (done) begin
      state_d   = IDLE;
      discard_d = 1'b0;
      if (!suppress) begin
        unique case (owner_q)
          OWN_ST:  st_ack_d = 1'b1;
          OWN_LB:  begin lb_ack_d = 1'b1; lb_data_d = mc_data_in; end
          default: begin if_ack_d = 1'b1; if_data_d = mc_data_in; end
        endcase
      end
      // Under discard the owner's flag was already cleared by the flush and may
      // now belong to a fresh request.
      if (!discard_q) begin
        unique case (owner_q)
          OWN_ST:  st_pend_d = 1'b0;
          OWN_LB:  lb_pend_d = 1'b0;
          default: if_pend_d = 1'b0;
        endcase
      end
    end else if (state_q == WAIT && flush_in && owner_q != OWN_ST) begin
      discard_d = 1'b1;
    end

    if (!if_pend_q)                  starve_d = '0;
    else if (grant && win == OWN_IF) starve_d = '0;
    else if (grant && starve_q != LIMIT) starve_d = starve_q + CNT_W'(1);

    if (flush_in) begin
      if_pend_d = 1'b0;
      lb_pend_d = 1'b0;
    end

    if (if_req_in && !if_pend_q && !flush_in) begin
      if_pend_d = 1'b1; if_addr_d = if_addr_in;
    end
    if (lb_req_in && !lb_pend_q && !flush_in) begin
      lb_pend_d = 1'b1; lb_addr_d = lb_addr_in; lb_len_d = lb_len_in;
    end
    if (st_req_in && !st_pend_q) begin
      st_pend_d = 1'b1; st_addr_d = st_addr_in; st_len_d = st_len_in; st_data_d = st_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      discard_q  <= 1'b0;
      starve_q   <= '0;
      if_pend_q  <= 1'b0;
      lb_pend_q  <= 1'b0;
      st_pend_q  <= 1'b0;
      if_addr_q  <= '0;
      lb_addr_q  <= '0;
      st_addr_q  <= '0;
      lb_len_q   <= '0;
      st_len_q   <= '0;
      st_data_q  <= '0;
      mc_start_q <= 1'b0;
      mc_rw_q    <= 1'b0;
      mc_addr_q  <= '0;
      mc_len_q   <= '0;
      mc_data_q  <= '0;
      if_ack_q   <= 1'b0;
      lb_ack_q   <= 1'b0;
      st_ack_q   <= 1'b0;
      if_data_q  <= '0;
      lb_data_q  <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      discard_q  <= discard_d;
      starve_q   <= starve_d;
      if_pend_q  <= if_pend_d;
      lb_pend_q  <= lb_pend_d;
      st_pend_q  <= st_pend_d;
      if_addr_q  <= if_addr_d;
      lb_addr_q  <= lb_addr_d;
      st_addr_q  <= st_addr_d;
      lb_len_q   <= lb_len_d;
      st_len_q   <= st_len_d;
      st_data_q  <= st_data_d;
      mc_start_q <= mc_start_d;
      mc_rw_q    <= mc_rw_d;
      mc_addr_q  <= mc_addr_d;
      mc_len_q   <= mc_len_d;
      mc_data_q  <= mc_data_d;
      if_ack_q   <= if_ack_d;
      lb_ack_q   <= lb_ack_d;
      st_ack_q   <= st_ack_d;
      if_data_q  <= if_data_d;
      lb_data_q  <= lb_data_d;
    end
  end

  assign if_ack_out   = if_ack_q;
  assign if_data_out  = if_data_q;
  assign lb_ack_out   = lb_ack_q;
  assign lb_data_out  = lb_data_q;
  assign st_ack_out   = st_ack_q;
  assign mc_start_out = mc_start_q;
  assign mc_rw_out    = mc_rw_q;
  assign mc_addr_out  = mc_addr_q;
  assign mc_len_out   = mc_len_q;
  assign mc_data_out  = mc_data_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Schedules the single byte-serial memory controller among three requesters: instruction fetcher (IF), load buffer (LB) and committed-store path (ST).
- Latches one outstanding request per requester and grants by fixed priority ST > LB > IF, with a starvation guard for IF.
- Issues each granted request downstream with a start/done handshake and returns the ack/data to the owner.
- Handles pipeline flush so speculative IF/LB results are discarded while committed stores always complete.

Parameters:
STARVE_LIMIT, 4, consecutive non-IF grants tolerated while IF is pending before IF is forced next.
CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
clk  input  1  clock
rst  input  1  reset
rdy  input  1  global ready; low freezes all state
flush_in  input  1  mispredict flush
if_req_in  input  1  IF request pulse
if_addr_in  input  32  IF word address
if_ack_out  output  1  IF result valid pulse
if_data_out  output  32  fetched word
lb_req_in  input  1  load request pulse
lb_addr_in  input  32  load address
lb_len_in  input  2  0 byte, 1 half, 3 word
lb_ack_out  output  1  load result valid pulse
lb_data_out  output  32  raw load data, zero-extended
st_req_in  input  1  store request pulse
st_addr_in  input  32  store address
st_len_in  input  2  0 byte, 1 half, 3 word
st_data_in  input  32  store data
st_ack_out  output  1  store done pulse
mc_start_out  output  1  one-cycle start to memory controller
mc_rw_out  output  1  1 write, 0 read
mc_addr_out  output  32  request address
mc_len_out  output  2  request length; 3 for IF
mc_data_out  output  32  store data
mc_done_in  input  1  controller completion pulse
mc_data_in  input  32  read data, valid with mc_done_in

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset:
  - All *_ack_out, mc_start_out and mc_rw_out are 0.
  - mc_addr_out, mc_len_out, mc_data_out, if_data_out and lb_data_out are 0.
  - All pending flags, the discard flag and the starvation counter are cleared; state is IDLE.
- rdy low: every register holds its value. mc_done_in is not sampled, because the controller is frozen by the same rdy.
- Request latching:
  - A req pulse sampled at edge N sets that port's pending flag and captures addr/len/data.
  - Each requester guarantees at most one outstanding request, so a req arriving while that port is pending is ignored.
- States: IDLE, WAIT.
- IDLE, with any request pending:
  - Select the winner: IF if the starvation counter equals STARVE_LIMIT and IF is pending; otherwise ST > LB > IF.
  - Drive mc_* from the winner's captured fields.
  - Pulse mc_start_out for exactly one cycle and go to WAIT.
  - A request latched at edge N can start at edge N+1; it is visible to the controller in the cycle after N+1.
  - A request captured at the same edge as a grant decision is not considered until the next edge.
- Starvation counter:
  - Increments on an LB/ST grant while IF is pending, saturating at STARVE_LIMIT.
  - Clears on an IF grant, and whenever IF is not pending.
- WAIT, on mc_done_in:
  - Clear the owner's pending flag and return to IDLE; a new grant is possible on the next edge.
  - IF owner: register mc_data_in into if_data_out and pulse if_ack_out for one cycle.
  - LB owner: register mc_data_in into lb_data_out and pulse lb_ack_out for one cycle.
  - ST owner: pulse st_ack_out for one cycle.
  - If the discard flag is set, suppress the ack and data update, then clear discard.
- Ack pulses last exactly one cycle; the data outputs hold until the next ack for that port.
- Flush (flush_in high at an edge):
  - Clears IF and LB pending flags; a same-edge if_req_in or lb_req_in is dropped.
  - If in WAIT with an IF or LB owner, set discard. The controller transfer runs to completion and is never aborted mid-byte.
  - ST pending and an in-flight ST are unaffected.
  - Flush in IDLE with only IF/LB pending: no grant that edge.
- A store ack can coincide with a flush; the store ack is still delivered.

Test Plan:
- Reset: assert rst 2 cycles -> all outputs 0, state IDLE; no mc_start_out for 5 idle cycles afterwards.
- IF alone: if_req_in with addr 0x100, controller returns mc_done_in with data 0xDEADBEEF after 4 cycles -> mc_start_out once with mc_rw_out=0, mc_len_out=3; then if_ack_out=1 for one cycle with if_data_out=0xDEADBEEF.
- Priority: IF, LB and ST requested on the same edge -> grants in order ST, LB, IF; st_ack_out, lb_ack_out, if_ack_out pulse in that order; no overlap of mc_start_out with WAIT.
- Starvation: IF pending while 5 back-to-back LB/ST requests keep arriving, STARVE_LIMIT=4 -> IF is granted after the 4th non-IF grant, ahead of pending LB/ST.
- Flush during LB in WAIT: flush_in pulses while ST is also pending -> lb_ack_out never asserts and lb_data_out is unchanged; ST is then granted and st_ack_out pulses.
- rdy low for 3 cycles mid-WAIT -> no state change and no acks; behaviour resumes identically once rdy returns high.
